pc_fetch_unit: RTL and testbench

//  Owns the architectural fetch PC and closes the loop with the next-PC selector:

---
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 tb/tb_pc_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// F-stage fetch PC owner: reset boot, exception/ERET redirection, stall hold,
// delay-slot tagging, fetch-side AdEL detection and a fetch advance counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI   = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        ctrl_xfer_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_F,
  output logic        valid_F,
  output logic        bd_F,
  output logic        exc_F,
  output logic [4:0]  exccode_F,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned ECW  = 5;
  localparam logic [ECW-1:0] EXC_ADEL = ECW'(4);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              bd_q, bd_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;

  // State and fetch registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      bd_q    <= bd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and redirect selection: exc > eret (RUN only) > stall > normal.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    bd_d    = bd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN, ST_KILL: begin
        state_d = ST_RUN;
        if (exc_req) begin
          pc_d    = EXC_ENTRY;
          valid_d = 1'b1;
          bd_d    = 1'b0;
          cnt_d   = cnt_q + XLEN'(1);
        end else if (eret_req && (state_q == ST_RUN)) begin
          state_d = ST_KILL;
          pc_d    = epc;
          valid_d = 1'b1;
          bd_d    = 1'b0;
          cnt_d   = cnt_q + XLEN'(1);
        end else if (!stall) begin
          pc_d    = next_pc;
          valid_d = 1'b1;
          bd_d    = ctrl_xfer_D;
          cnt_d   = cnt_q + XLEN'(1);
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign pc_F      = pc_q;
  assign valid_F   = valid_q;
  assign bd_F      = bd_q;
  assign fetch_cnt = cnt_q;

  // AdEL: misaligned or outside the instruction memory window.
  assign exc_F     = valid_q & ((|pc_q[1:0]) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI));
  assign exccode_F = exc_F ? EXC_ADEL : ECW'(0);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vectors, per-cycle model
// comparison and hand-computed literal expectations.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        ctrl_xfer_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_F;
  logic        valid_F;
  logic        bd_F;
  logic        exc_F;
  logic [4:0]  exccode_F;
  logic [31:0] fetch_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .stall       (stall),
    .ctrl_xfer_D (ctrl_xfer_D),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc_F        (pc_F),
    .valid_F     (valid_F),
    .bd_F        (bd_F),
    .exc_F       (exc_F),
    .exccode_F   (exccode_F),
    .fetch_cnt   (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: architectural fetch state updated from the rules.
  logic [31:0] m_pc;
  logic        m_valid, m_bd;
  logic [31:0] m_cnt;
  bit          m_known = 0;
  bit          m_booting, m_eret_shadow;

  always @(posedge clk) begin
    if (!reset) begin
      m_known = 1; m_booting = 1; m_eret_shadow = 0;
      m_pc = 32'h0000_3000; m_valid = 0; m_bd = 0; m_cnt = 0;
    end else if (m_known) begin
      if (m_booting) begin
        m_booting = 0;
        m_valid = 1;
      end else if (exc_req) begin
        m_pc = 32'h0000_4180; m_valid = 1; m_bd = 0; m_cnt = m_cnt + 1;
        m_eret_shadow = 0;
      end else if (eret_req && !m_eret_shadow) begin
        m_pc = epc; m_valid = 1; m_bd = 0; m_cnt = m_cnt + 1;
        m_eret_shadow = 1;
      end else begin
        m_eret_shadow = 0;
        if (!stall) begin
          m_pc = next_pc; m_valid = 1; m_bd = ctrl_xfer_D; m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_known) begin
      automatic bit exp_exc = m_valid && ((m_pc % 4) != 0 || m_pc < 32'h3000 || m_pc > 32'h6ffc);
      check("m_pc",      pc_F,                m_pc);
      check("m_valid",   32'(valid_F),        32'(m_valid));
      check("m_bd",      32'(bd_F),           32'(m_bd));
      check("m_cnt",     fetch_cnt,           m_cnt);
      check("m_exc",     32'(exc_F),          32'(exp_exc));
      check("m_exccode", 32'(exccode_F),      exp_exc ? 32'd4 : 32'd0);
    end
  end

  task automatic cyc(input logic [31:0] np, input logic st, input logic cx,
                     input logic ex, input logic er, input logic [31:0] ep);
    next_pc = np; stall = st; ctrl_xfer_D = cx; exc_req = ex; eret_req = er; epc = ep;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; next_pc = '0; stall = 0; ctrl_xfer_D = 0;
    exc_req = 0; eret_req = 0; epc = '0;
    @(negedge clk); @(negedge clk);
    check("rst_pc", pc_F, 32'h3000);
    check("rst_valid", 32'(valid_F), 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);

    // Boot: one cycle holding RESET_PC, stall ignored.
    reset = 1'b1;
    cyc(32'h3abc, 1, 0, 0, 0, 0);
    check("boot_pc", pc_F, 32'h3000);
    check("boot_valid", 32'(valid_F), 32'd1);
    check("boot_cnt", fetch_cnt, 32'd0);
    cyc(32'h3004, 0, 0, 0, 0, 0);
    check("first_adv_pc", pc_F, 32'h3004);
    check("first_adv_cnt", fetch_cnt, 32'd1);
    cyc(32'h3008, 0, 0, 0, 0, 0);
    cyc(32'h300c, 0, 0, 0, 0, 0);
    cyc(32'h3010, 0, 0, 0, 0, 0);

    // Stall three cycles; next_pc garbage must not leak in.
    cyc(32'h3010, 1, 1, 0, 0, 0);
    cyc(32'hdead_beef, 1, 1, 0, 0, 0);
    cyc(32'h3010, 1, 0, 0, 0, 0);
    check("stall_pc", pc_F, 32'h3010);
    check("stall_bd", 32'(bd_F), 32'd0);
    check("stall_cnt", fetch_cnt, 32'd4);
    cyc(32'h3014, 0, 0, 0, 0, 0);
    check("unstall_pc", pc_F, 32'h3014);

    // Delay-slot tagging.
    cyc(32'h3020, 0, 1, 0, 0, 0);
    check("bd_pc", pc_F, 32'h3020);
    check("bd_set", 32'(bd_F), 32'd1);
    cyc(32'h3024, 0, 0, 0, 0, 0);
    check("bd_clr", 32'(bd_F), 32'd0);
    cyc(32'h3028, 0, 1, 0, 0, 0);

    // Exception beats eret and stall.
    cyc(32'h3028, 1, 1, 1, 1, 32'h3500);
    check("exc_pc", pc_F, 32'h4180);
    check("exc_bd", 32'(bd_F), 32'd0);
    check("exc_cnt", fetch_cnt, 32'd9);
    cyc(32'h4184, 0, 0, 0, 0, 0);

    // ERET then a second ERET ignored in KILL.
    cyc(32'h4188, 0, 1, 0, 1, 32'h3104);
    check("eret_pc", pc_F, 32'h3104);
    check("eret_bd", 32'(bd_F), 32'd0);
    cyc(32'h3108, 0, 0, 0, 1, 32'h3200);
    check("kill_eret_ign", pc_F, 32'h3108);
    check("kill_cnt", fetch_cnt, 32'd12);
    cyc(32'h310c, 0, 0, 0, 1, 32'h3300);
    check("eret2_pc", pc_F, 32'h3300);
    cyc(32'h3304, 0, 0, 1, 1, 32'h3400);
    check("kill_exc_pc", pc_F, 32'h4180);
    cyc(32'h4184, 0, 0, 0, 1, 32'h3400);
    cyc(32'h3777, 1, 0, 0, 1, 32'h3500);
    check("kill_stall_pc", pc_F, 32'h3400);
    cyc(32'h3404, 0, 0, 0, 0, 0);

    // AdEL boundaries.
    cyc(32'h3002, 0, 0, 0, 0, 0);
    check("adel_mis", 32'(exc_F), 32'd1);
    check("adel_code", 32'(exccode_F), 32'd4);
    cyc(32'h7000, 0, 0, 0, 0, 0);
    check("adel_hi", 32'(exc_F), 32'd1);
    cyc(32'h6ffc, 0, 0, 0, 0, 0);
    check("ok_hi", 32'(exc_F), 32'd0);
    check("ok_code", 32'(exccode_F), 32'd0);
    cyc(32'h2ffc, 0, 0, 0, 0, 0);
    check("adel_lo", 32'(exc_F), 32'd1);
    cyc(32'h3000, 0, 0, 0, 0, 0);
    check("ok_lo", 32'(exc_F), 32'd0);

    // Mixed random traffic checked by the model.
    for (int i = 0; i < 200; i++) begin
      cyc(32'h3000 + ($urandom_range(0, 32'h1000) << 2) + 32'($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          32'h3000 + ($urandom_range(0, 32'h1000) << 2));
    end

    // Reset wins over a simultaneous ERET.
    reset = 1'b0;
    cyc(32'h3040, 0, 0, 0, 1, 32'h3600);
    check("midrst_pc", pc_F, 32'h3000);
    check("midrst_cnt", fetch_cnt, 32'd0);
    check("midrst_valid", 32'(valid_F), 32'd0);
    reset = 1'b1;
    cyc(32'h3abc, 0, 0, 0, 0, 0);
    cyc(32'h3004, 0, 0, 0, 0, 0);
    check("rerun_pc", pc_F, 32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
